// File: rtl/fwrisc_wb_arb_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package fwrisc_wb_arb_pkg;
   localparam int REG_AW   = 6;
   localparam int STARVE_W = 8;

   typedef enum logic [1:0] {WB_EXEC, WB_LSU, WB_DBG} wb_src_t;
   typedef enum logic {ARB_NORMAL, ARB_BOOST} arb_state_t;
endpackage

// File: rtl/fwrisc_wb_scoreboard.sv
// Pending-load scoreboard: one bit per register slot, set on load issue, cleared on load return.
module fwrisc_wb_scoreboard
   import fwrisc_wb_arb_pkg::*;
#(
   parameter int NUM_REGS = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              set_valid,
   input  logic [REG_AW-1:0] set_addr,
   input  logic              clr_valid,
   input  logic [REG_AW-1:0] clr_addr,
   input  logic [REG_AW-1:0] ra_addr,
   input  logic [REG_AW-1:0] rb_addr,
   input  logic [REG_AW-1:0] rc_addr,
   output logic              hit_a,
   output logic              hit_b,
   output logic              hit_c
);

   logic [NUM_REGS-1:0] pending_q;
   logic [NUM_REGS-1:0] pending_d;

   // Set is applied after clear so a same-edge reserve of a returning register wins.
   always_comb begin
      pending_d = pending_q;
      if (clr_valid)
         pending_d[clr_addr] = 1'b0;
      if (set_valid && (set_addr != '0))
         pending_d[set_addr] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         pending_q <= '0;
      else
         pending_q <= pending_d;
   end

   assign hit_a = pending_q[ra_addr];
   assign hit_b = pending_q[rb_addr];
   assign hit_c = pending_q[rc_addr];

endmodule

// File: rtl/fwrisc_wb_arbiter.sv
// Register-file write-port arbiter: exec > lsu > dbg with starvation boost for dbg.
// Optional stall counter built when FWRISC_WB_ARB_PERF_EN is defined.
//
// state      | meaning
// ARB_NORMAL | fixed priority exec > lsu > dbg, starve counter running
// ARB_BOOST  | dbg owns the port, exec and lsu held off
module fwrisc_wb_arbiter
   import fwrisc_wb_arb_pkg::*;
#(
   parameter int NUM_REGS     = 64,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              exec_valid,
   output logic              exec_ready,
   input  logic [REG_AW-1:0] exec_addr,
   input  logic [31:0]       exec_data,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic [REG_AW-1:0] lsu_addr,
   input  logic [31:0]       lsu_data,
   input  logic              dbg_valid,
   output logic              dbg_ready,
   input  logic [REG_AW-1:0] dbg_addr,
   input  logic [31:0]       dbg_data,
   input  logic              rsv_valid,
   input  logic [REG_AW-1:0] rsv_addr,
   input  logic [REG_AW-1:0] ra_raddr,
   input  logic [REG_AW-1:0] rb_raddr,
   output logic              hazard_a,
   output logic              hazard_b,
   output logic [REG_AW-1:0] rd_waddr,
   output logic [31:0]       rd_wdata,
   output logic              rd_wen,
   output logic [31:0]       stall_cycles
);

   localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

   arb_state_t          state_q, state_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                exec_pending;
   logic                exec_xfer, lsu_xfer, dbg_xfer;
   logic                win_valid;
   wb_src_t             win_src;
   logic [REG_AW-1:0]   win_addr;
   logic [31:0]         win_data;

   fwrisc_wb_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
      .clock     (clock),
      .reset     (reset),
      .set_valid (rsv_valid),
      .set_addr  (rsv_addr),
      .clr_valid (lsu_xfer),
      .clr_addr  (lsu_addr),
      .ra_addr   (ra_raddr),
      .rb_addr   (rb_raddr),
      .rc_addr   (exec_addr),
      .hit_a     (hazard_a),
      .hit_b     (hazard_b),
      .hit_c     (exec_pending)
   );

   // Ready depends only on valids, state and scoreboard, never on data.
   always_comb begin
      exec_ready = 1'b0;
      lsu_ready  = 1'b0;
      dbg_ready  = 1'b0;
      if (state_q == ARB_BOOST) begin
         dbg_ready = 1'b1;
      end else begin
         exec_ready = !exec_pending;
         lsu_ready  = !(exec_valid && exec_ready);
         dbg_ready  = !(exec_valid && exec_ready) && !(lsu_valid && lsu_ready);
      end
   end

   assign exec_xfer = exec_valid && exec_ready;
   assign lsu_xfer  = lsu_valid && lsu_ready;
   assign dbg_xfer  = dbg_valid && dbg_ready;

   always_comb begin
      win_valid = exec_xfer || lsu_xfer || dbg_xfer;
      win_src   = WB_EXEC;
      if (!exec_xfer && lsu_xfer)
         win_src = WB_LSU;
      else if (!exec_xfer && dbg_xfer)
         win_src = WB_DBG;
      win_addr = exec_addr;
      win_data = exec_data;
      case (win_src)
         WB_LSU: begin
            win_addr = lsu_addr;
            win_data = lsu_data;
         end
         WB_DBG: begin
            win_addr = dbg_addr;
            win_data = dbg_data;
         end
         default: begin
            win_addr = exec_addr;
            win_data = exec_data;
         end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      // Counter saturates at the limit; the boost decision is taken from the registered value.
      if (!dbg_valid || dbg_xfer)
         starve_d = '0;
      else if ((state_q == ARB_NORMAL) && (starve_q != LIMIT))
         starve_d = starve_q + 1'b1;
      case (state_q)
         ARB_NORMAL: if (dbg_valid && !dbg_xfer && (starve_q == LIMIT)) state_d = ARB_BOOST;
         ARB_BOOST:  if (!dbg_valid || dbg_xfer) state_d = ARB_NORMAL;
         default:    state_d = ARB_NORMAL;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ARB_NORMAL;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   // Writes to x0 are accepted upstream but never reach the regfile.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_wen   <= 1'b0;
         rd_waddr <= '0;
         rd_wdata <= '0;
      end else begin
         rd_wen <= win_valid && (win_addr != '0);
         if (win_valid && (win_addr != '0)) begin
            rd_waddr <= win_addr;
            rd_wdata <= win_data;
         end
      end
   end

`ifdef FWRISC_WB_ARB_PERF_EN
   logic        any_refused;
   logic [31:0] stall_q;

   assign any_refused = (exec_valid && !exec_ready) || (lsu_valid && !lsu_ready) ||
                        (dbg_valid && !dbg_ready);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         stall_q <= '0;
      else if (any_refused)
         stall_q <= stall_q + 32'd1;
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fwrisc_wb_arbiter.sv
// Directed bench for fwrisc_wb_arbiter: vector table plus starvation, reset and perf sequences.
module tb_fwrisc_wb_arbiter;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        exec_valid, lsu_valid, dbg_valid, rsv_valid;
   logic        exec_ready, lsu_ready, dbg_ready;
   logic [5:0]  exec_addr, lsu_addr, dbg_addr, rsv_addr, ra_raddr, rb_raddr;
   logic [31:0] exec_data, lsu_data, dbg_data;
   logic        hazard_a, hazard_b, rd_wen;
   logic [5:0]  rd_waddr;
   logic [31:0] rd_wdata, stall_cycles;

   int n_vec = 0;
   int n_bad = 0;

   fwrisc_wb_arbiter #(.NUM_REGS(64), .STARVE_LIMIT(8)) dut (
      .clock        (clock),
      .reset        (reset),
      .exec_valid   (exec_valid),
      .exec_ready   (exec_ready),
      .exec_addr    (exec_addr),
      .exec_data    (exec_data),
      .lsu_valid    (lsu_valid),
      .lsu_ready    (lsu_ready),
      .lsu_addr     (lsu_addr),
      .lsu_data     (lsu_data),
      .dbg_valid    (dbg_valid),
      .dbg_ready    (dbg_ready),
      .dbg_addr     (dbg_addr),
      .dbg_data     (dbg_data),
      .rsv_valid    (rsv_valid),
      .rsv_addr     (rsv_addr),
      .ra_raddr     (ra_raddr),
      .rb_raddr     (rb_raddr),
      .hazard_a     (hazard_a),
      .hazard_b     (hazard_b),
      .rd_waddr     (rd_waddr),
      .rd_wdata     (rd_wdata),
      .rd_wen       (rd_wen),
      .stall_cycles (stall_cycles)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic ev; logic [5:0] ea; logic [31:0] ed;
      logic lv; logic [5:0] la; logic [31:0] ld;
      logic dv; logic [5:0] da; logic [31:0] dd;
      logic rv; logic [5:0] rva;
      logic [5:0] ra; logic [5:0] rb;
      logic x_er; logic x_lr; logic x_dr;
      logic x_ha; logic x_hb;
      logic x_wen; logic [5:0] x_wa; logic [31:0] x_wd;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      exec_valid = 0; exec_addr = 0; exec_data = 0;
      lsu_valid  = 0; lsu_addr  = 0; lsu_data  = 0;
      dbg_valid  = 0; dbg_addr  = 0; dbg_data  = 0;
      rsv_valid  = 0; rsv_addr  = 0;
      ra_raddr   = 0; rb_raddr  = 0;
   endtask

   // Leaves the bench 1 time unit after a posedge with reset released.
   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   initial begin
      //          ev ea  ed          lv la  ld          dv da  dd          rv rva ra rb  er lr dr ha hb wen wa  wd
      vecs[0]  = '{0, 0,  32'h0,     0, 0,  32'h0,     0, 0,  32'h0,     0, 0,  0, 0,  1, 1, 1, 0, 0, 0, 0,  32'h0};
      vecs[1]  = '{1, 5,  32'h11,    1, 6,  32'h22,    0, 0,  32'h0,     0, 0,  0, 0,  1, 0, 0, 0, 0, 1, 5,  32'h11};
      vecs[2]  = '{0, 0,  32'h0,     1, 6,  32'h22,    0, 0,  32'h0,     0, 0,  0, 0,  1, 1, 0, 0, 0, 1, 6,  32'h22};
      vecs[3]  = '{0, 0,  32'h0,     0, 0,  32'h0,     0, 0,  32'h0,     1, 7,  7, 0,  1, 1, 1, 0, 0, 0, 6,  32'h22};
      vecs[4]  = '{1, 7,  32'h33,    0, 0,  32'h0,     0, 0,  32'h0,     0, 0,  7, 0,  0, 1, 1, 1, 0, 0, 6,  32'h22};
      vecs[5]  = '{1, 7,  32'h33,    1, 7,  32'hAB,    0, 0,  32'h0,     0, 0,  7, 7,  0, 1, 0, 1, 1, 1, 7,  32'hAB};
      vecs[6]  = '{1, 7,  32'h33,    0, 0,  32'h0,     0, 0,  32'h0,     0, 0,  7, 7,  1, 0, 0, 0, 0, 1, 7,  32'h33};
      vecs[7]  = '{1, 0,  32'hFFFF,  0, 0,  32'h0,     0, 0,  32'h0,     0, 0,  0, 0,  1, 0, 0, 0, 0, 0, 7,  32'h33};
      vecs[8]  = '{0, 0,  32'h0,     1, 3,  32'h44,    0, 0,  32'h0,     1, 3,  0, 3,  1, 1, 0, 0, 0, 1, 3,  32'h44};
      vecs[9]  = '{0, 0,  32'h0,     0, 0,  32'h0,     0, 0,  32'h0,     0, 0,  0, 3,  1, 1, 1, 0, 1, 0, 3,  32'h44};
      vecs[10] = '{0, 0,  32'h0,     1, 3,  32'h55,    0, 0,  32'h0,     0, 0,  0, 3,  1, 1, 0, 0, 1, 1, 3,  32'h55};
      vecs[11] = '{0, 0,  32'h0,     0, 0,  32'h0,     0, 0,  32'h0,     1, 0,  0, 3,  1, 1, 1, 0, 0, 0, 3,  32'h55};
      vecs[12] = '{0, 0,  32'h0,     0, 0,  32'h0,     0, 0,  32'h0,     0, 0,  0, 0,  1, 1, 1, 0, 0, 0, 3,  32'h55};
      vecs[13] = '{0, 0,  32'h0,     0, 0,  32'h0,     1, 9,  32'h99,    0, 0,  0, 0,  1, 1, 1, 0, 0, 1, 9,  32'h99};
      vecs[14] = '{0, 0,  32'h0,     1, 10, 32'hA0,    1, 11, 32'hB0,    0, 0,  0, 0,  1, 1, 0, 0, 0, 1, 10, 32'hA0};
      vecs[15] = '{0, 0,  32'h0,     0, 0,  32'h0,     1, 11, 32'hB0,    0, 0,  0, 0,  1, 1, 1, 0, 0, 1, 11, 32'hB0};
      vecs[16] = '{1, 12, 32'hC0,    0, 0,  32'h0,     1, 11, 32'hB0,    0, 0,  0, 0,  1, 0, 0, 0, 0, 1, 12, 32'hC0};

      do_reset();
      chk("reset rd_wen", {31'b0, rd_wen}, 32'd0);
      chk("reset rd_waddr", {26'b0, rd_waddr}, 32'd0);
      chk("reset rd_wdata", rd_wdata, 32'd0);
      chk("reset stall_cycles", stall_cycles, 32'd0);

      // Vector table: inputs applied after a posedge, readies/hazards checked mid-cycle,
      // write port checked just after the next posedge.
      for (int i = 0; i < 17; i++) begin
         exec_valid = vecs[i].ev; exec_addr = vecs[i].ea; exec_data = vecs[i].ed;
         lsu_valid  = vecs[i].lv; lsu_addr  = vecs[i].la; lsu_data  = vecs[i].ld;
         dbg_valid  = vecs[i].dv; dbg_addr  = vecs[i].da; dbg_data  = vecs[i].dd;
         rsv_valid  = vecs[i].rv; rsv_addr  = vecs[i].rva;
         ra_raddr   = vecs[i].ra; rb_raddr  = vecs[i].rb;
         #2;
         chk($sformatf("v%0d exec_ready", i), {31'b0, exec_ready}, {31'b0, vecs[i].x_er});
         chk($sformatf("v%0d lsu_ready", i),  {31'b0, lsu_ready},  {31'b0, vecs[i].x_lr});
         chk($sformatf("v%0d dbg_ready", i),  {31'b0, dbg_ready},  {31'b0, vecs[i].x_dr});
         chk($sformatf("v%0d hazard_a", i),   {31'b0, hazard_a},   {31'b0, vecs[i].x_ha});
         chk($sformatf("v%0d hazard_b", i),   {31'b0, hazard_b},   {31'b0, vecs[i].x_hb});
         @(posedge clock);
         #1;
         chk($sformatf("v%0d rd_wen", i),   {31'b0, rd_wen},   {31'b0, vecs[i].x_wen});
         chk($sformatf("v%0d rd_waddr", i), {26'b0, rd_waddr}, {26'b0, vecs[i].x_wa});
         chk($sformatf("v%0d rd_wdata", i), rd_wdata, vecs[i].x_wd);
      end

      // Starvation: exec held, dbg refused until its boost cycle (cycle 10).
      do_reset();
      for (int c = 1; c <= 11; c++) begin
         exec_valid = 1; exec_addr = 1; exec_data = c;
         dbg_valid  = 1; dbg_addr  = 2; dbg_data  = 32'hD0;
         #2;
         chk($sformatf("starve c%0d exec_ready", c), {31'b0, exec_ready}, (c != 10) ? 32'd1 : 32'd0);
         chk($sformatf("starve c%0d dbg_ready", c),  {31'b0, dbg_ready},  (c == 10) ? 32'd1 : 32'd0);
         @(posedge clock);
         #1;
         if (c == 10) begin
            chk("starve dbg waddr", {26'b0, rd_waddr}, 32'd2);
            chk("starve dbg wdata", rd_wdata, 32'hD0);
         end
         if (c == 11) begin
            chk("starve exec waddr", {26'b0, rd_waddr}, 32'd1);
            chk("starve exec wdata", rd_wdata, 32'd11);
         end
      end

      // Reset while in BOOST with a dbg transfer and a pending load outstanding.
      do_reset();
      for (int c = 1; c <= 10; c++) begin
         exec_valid = 1; exec_addr = 1; exec_data = 32'h1;
         dbg_valid  = 1; dbg_addr  = 2; dbg_data  = 32'hE0;
         rsv_valid  = (c == 1); rsv_addr = 4; ra_raddr = 4;
         #2;
         if (c < 10) begin
            @(posedge clock);
            #1;
         end
      end
      chk("boost dbg_ready", {31'b0, dbg_ready}, 32'd1);
      chk("boost hazard_a", {31'b0, hazard_a}, 32'd1);
      #1 reset = 1'b1;
      @(posedge clock);
      #1;
      chk("rst boost rd_wen", {31'b0, rd_wen}, 32'd0);
      chk("rst boost rd_waddr", {26'b0, rd_waddr}, 32'd0);
      chk("rst boost rd_wdata", rd_wdata, 32'd0);
      chk("rst boost stall", stall_cycles, 32'd0);
      reset = 1'b0;
      #2;
      chk("post rst exec_ready", {31'b0, exec_ready}, 32'd1);
      chk("post rst dbg_ready", {31'b0, dbg_ready}, 32'd0);
      chk("post rst hazard_a", {31'b0, hazard_a}, 32'd0);

      // Perf: lsu held off by exec for 4 cycles, then granted.
      do_reset();
      for (int c = 1; c <= 5; c++) begin
         exec_valid = (c <= 4); exec_addr = 1; exec_data = 32'h5;
         lsu_valid  = 1; lsu_addr = 2; lsu_data = 32'h22;
         #2;
         chk($sformatf("perf c%0d lsu_ready", c), {31'b0, lsu_ready}, (c == 5) ? 32'd1 : 32'd0);
         @(posedge clock);
         #1;
      end
      clear_inputs();
`ifdef FWRISC_WB_ARB_PERF_EN
      chk("perf stall_cycles", stall_cycles, 32'd4);
`else
      chk("perf stall_cycles", stall_cycles, 32'd0);
`endif
      chk("perf lsu waddr", {26'b0, rd_waddr}, 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
